// File: rtl/pc_rmw_ctrl_pkg.sv
// rtl/pc_rmw_ctrl_pkg.sv - shared sizes and state encoding for the slot read-modify-write controller
package pc_rmw_ctrl_pkg;

    localparam int DEF_NUM_SLOTS = 40;
    localparam int DEF_BITWIDTH  = 11;
    localparam int WFID_W        = 6;
    localparam int AMT_W         = 4;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    typedef enum logic {
        KIND_INIT = 1'b0,
        KIND_INCR = 1'b1
    } req_kind_t;

endpackage

// File: rtl/pc_rmw_ctrl.sv
// rtl/pc_rmw_ctrl.sv - per-slot counter controller: clear sweep, then one-stage init/increment read-modify-write
module pc_rmw_ctrl
    import pc_rmw_ctrl_pkg::*;
#(
    parameter int BITWIDTH  = DEF_BITWIDTH,
    parameter int NUM_SLOTS = DEF_NUM_SLOTS
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init_valid,
    input  logic [WFID_W-1:0]   init_wfid,
    input  logic [BITWIDTH-1:0] init_value,
    output logic                init_ready,
    input  logic                incr_valid,
    input  logic [WFID_W-1:0]   incr_wfid,
    input  logic [AMT_W-1:0]    incr_amount,
    output logic                incr_ready,
    input  logic                flush_req,
    output logic [WFID_W-1:0]   rf_readregsel,
    input  logic [BITWIDTH-1:0] rf_readdata,
    output logic                rf_write,
    output logic [WFID_W-1:0]   rf_writeregsel,
    output logic [BITWIDTH-1:0] rf_writedata,
    output logic                upd_valid,
    output logic [WFID_W-1:0]   upd_wfid,
    output logic [BITWIDTH-1:0] upd_value,
    output logic                upd_ovf,
    output logic                err_wfid,
    output logic                clear_done
);

    localparam logic [WFID_W:0]   SLOT_LIMIT = (WFID_W+1)'(NUM_SLOTS);
    localparam logic [WFID_W-1:0] LAST_SLOT  = WFID_W'(NUM_SLOTS - 1);

    logic [0:0]          state;
    logic [WFID_W-1:0]   counter;
    logic                stg_valid;
    req_kind_t           stg_kind;
    logic [WFID_W-1:0]   stg_wfid;
    logic [BITWIDTH-1:0] stg_operand;

    logic                in_run;
    logic                init_acc;
    logic                incr_acc;
    logic                stg_in_range;
    logic [BITWIDTH:0]   sum;
    logic [BITWIDTH-1:0] new_value;
    logic                new_ovf;
    logic                do_write;

    assign in_run = (state == ST_RUN);

    // A flush cycle still drains the stage but never admits new work.
    assign init_ready = in_run & ~flush_req;
    assign incr_ready = in_run & ~flush_req & ~init_valid;
    assign init_acc   = init_valid & init_ready;
    assign incr_acc   = incr_valid & incr_ready;

    assign stg_in_range = ({1'b0, stg_wfid} < SLOT_LIMIT);
    assign sum          = {1'b0, rf_readdata} + {1'b0, stg_operand};
    assign new_value    = (stg_kind == KIND_INIT) ? stg_operand : sum[BITWIDTH-1:0];
    assign new_ovf      = (stg_kind == KIND_INCR) & sum[BITWIDTH];
    assign do_write     = in_run & stg_valid & stg_in_range;

    always_comb begin
        rf_write       = 1'b0;
        rf_readregsel  = '0;
        rf_writeregsel = '0;
        rf_writedata   = '0;
        if (!in_run) begin
            rf_write       = 1'b1;
            rf_writeregsel = counter;
        end else if (stg_valid) begin
            rf_readregsel  = stg_wfid;
            rf_writeregsel = stg_wfid;
            rf_write       = stg_in_range;
            rf_writedata   = new_value;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_CLEAR;
            counter     <= '0;
            stg_valid   <= 1'b0;
            stg_kind    <= KIND_INIT;
            stg_wfid    <= '0;
            stg_operand <= '0;
            upd_valid   <= 1'b0;
            upd_wfid    <= '0;
            upd_value   <= '0;
            upd_ovf     <= 1'b0;
            err_wfid    <= 1'b0;
            clear_done  <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            upd_valid  <= do_write;
            upd_ovf    <= do_write & new_ovf;
            err_wfid   <= in_run & stg_valid & ~stg_in_range;
            if (do_write) begin
                upd_wfid  <= stg_wfid;
                upd_value <= new_value;
            end

            stg_valid <= init_acc | incr_acc;
            if (init_acc) begin
                stg_kind    <= KIND_INIT;
                stg_wfid    <= init_wfid;
                stg_operand <= init_value;
            end else if (incr_acc) begin
                stg_kind    <= KIND_INCR;
                stg_wfid    <= incr_wfid;
                stg_operand <= BITWIDTH'(incr_amount);
            end

            case (state)
                ST_CLEAR: begin
                    if (counter == LAST_SLOT) begin
                        counter    <= '0;
                        state      <= ST_RUN;
                        clear_done <= 1'b1;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: begin
                    if (flush_req) begin
                        state   <= ST_CLEAR;
                        counter <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_rmw_ctrl.sv
// tb/tb_pc_rmw_ctrl.sv - directed self-checking bench for pc_rmw_ctrl with a behavioural register block
module tb_pc_rmw_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_valid = 1'b0;
    logic [5:0]  init_wfid = '0;
    logic [10:0] init_value = '0;
    logic        init_ready;
    logic        incr_valid = 1'b0;
    logic [5:0]  incr_wfid = '0;
    logic [3:0]  incr_amount = '0;
    logic        incr_ready;
    logic        flush_req = 1'b0;
    logic [5:0]  rf_readregsel;
    logic [10:0] rf_readdata;
    logic        rf_write;
    logic [5:0]  rf_writeregsel;
    logic [10:0] rf_writedata;
    logic        upd_valid;
    logic [5:0]  upd_wfid;
    logic [10:0] upd_value;
    logic        upd_ovf;
    logic        err_wfid;
    logic        clear_done;

    int checks = 0;
    int errors = 0;

    logic [10:0] mem [0:63];

    always #5 clk = ~clk;

    assign rf_readdata = mem[rf_readregsel];
    always @(posedge clk) if (rf_write) mem[rf_writeregsel] <= rf_writedata;

    pc_rmw_ctrl #(.BITWIDTH(11), .NUM_SLOTS(40)) dut (
        .clk(clk), .rst(rst),
        .init_valid(init_valid), .init_wfid(init_wfid), .init_value(init_value), .init_ready(init_ready),
        .incr_valid(incr_valid), .incr_wfid(incr_wfid), .incr_amount(incr_amount), .incr_ready(incr_ready),
        .flush_req(flush_req),
        .rf_readregsel(rf_readregsel), .rf_readdata(rf_readdata),
        .rf_write(rf_write), .rf_writeregsel(rf_writeregsel), .rf_writedata(rf_writedata),
        .upd_valid(upd_valid), .upd_wfid(upd_wfid), .upd_value(upd_value), .upd_ovf(upd_ovf),
        .err_wfid(err_wfid), .clear_done(clear_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep(input int first, input string tag);
        for (int i = first; i < 40; i++) begin
            checks++; if (rf_write !== 1'b1 || rf_writeregsel !== 6'(i) || rf_writedata !== 11'h000) begin errors++; $display("FAIL %s sweep slot %0d got wr=%0b sel=%0d data=%h want wr=1 sel=%0d data=000", tag, i, rf_write, rf_writeregsel, rf_writedata, i); end
            checks++; if (init_ready !== 1'b0 || incr_ready !== 1'b0 || clear_done !== 1'b0) begin errors++; $display("FAIL %s sweep ready/done slot %0d got ir=%0b cr=%0b cd=%0b want 0 0 0", tag, i, init_ready, incr_ready, clear_done); end
            step();
        end
        checks++; if (clear_done !== 1'b1) begin errors++; $display("FAIL %s clear_done got %0b want 1", tag, clear_done); end
        checks++; if (init_ready !== 1'b1 || rf_write !== 1'b0 || rf_readregsel !== 6'd0) begin errors++; $display("FAIL %s run idle got ir=%0b wr=%0b rsel=%0d want 1 0 0", tag, init_ready, rf_write, rf_readregsel); end
        step();
        checks++; if (clear_done !== 1'b0) begin errors++; $display("FAIL %s clear_done pulse width got %0b want 0", tag, clear_done); end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        checks++; if (upd_valid !== 1'b0 || upd_ovf !== 1'b0 || err_wfid !== 1'b0 || clear_done !== 1'b0) begin errors++; $display("FAIL reset flags got uv=%0b uo=%0b ew=%0b cd=%0b want 0000", upd_valid, upd_ovf, err_wfid, clear_done); end
        checks++; if (upd_wfid !== 6'd0 || upd_value !== 11'h000) begin errors++; $display("FAIL reset upd regs got wfid=%0d val=%h want 0 000", upd_wfid, upd_value); end
        checks++; if (init_ready !== 1'b0 || rf_write !== 1'b1 || rf_writeregsel !== 6'd0) begin errors++; $display("FAIL reset clear state got ir=%0b wr=%0b sel=%0d want 0 1 0", init_ready, rf_write, rf_writeregsel); end
        rst = 1'b0;
        test_sweep(0, "reset");
    endtask

    task automatic test_init_incr();
        init_valid = 1'b1; init_wfid = 6'd5; init_value = 11'h100;
        #1;
        checks++; if (init_ready !== 1'b1) begin errors++; $display("FAIL ii init_ready got %0b want 1", init_ready); end
        step();
        init_valid = 1'b0; incr_valid = 1'b1; incr_wfid = 6'd5; incr_amount = 4'd4;
        #1;
        checks++; if (incr_ready !== 1'b1) begin errors++; $display("FAIL ii incr_ready got %0b want 1", incr_ready); end
        checks++; if (rf_write !== 1'b1 || rf_writeregsel !== 6'd5 || rf_writedata !== 11'h100) begin errors++; $display("FAIL ii init write got wr=%0b sel=%0d data=%h want 1 5 100", rf_write, rf_writeregsel, rf_writedata); end
        step();
        incr_valid = 1'b0;
        #1;
        checks++; if (rf_write !== 1'b1 || rf_readregsel !== 6'd5 || rf_writedata !== 11'h104) begin errors++; $display("FAIL ii incr write got wr=%0b rsel=%0d data=%h want 1 5 104", rf_write, rf_readregsel, rf_writedata); end
        checks++; if (upd_valid !== 1'b1 || upd_wfid !== 6'd5 || upd_value !== 11'h100 || upd_ovf !== 1'b0) begin errors++; $display("FAIL ii upd0 got v=%0b w=%0d val=%h o=%0b want 1 5 100 0", upd_valid, upd_wfid, upd_value, upd_ovf); end
        step();
        checks++; if (upd_valid !== 1'b1 || upd_value !== 11'h104 || upd_ovf !== 1'b0) begin errors++; $display("FAIL ii upd1 got v=%0b val=%h o=%0b want 1 104 0", upd_valid, upd_value, upd_ovf); end
        checks++; if (rf_write !== 1'b0 || rf_readregsel !== 6'd0) begin errors++; $display("FAIL ii idle got wr=%0b rsel=%0d want 0 0", rf_write, rf_readregsel); end
        step();
        checks++; if (upd_valid !== 1'b0) begin errors++; $display("FAIL ii upd drop got %0b want 0", upd_valid); end
    endtask

    task automatic test_overflow();
        init_valid = 1'b1; init_wfid = 6'd7; init_value = 11'h7FE;
        step();
        init_valid = 1'b0; incr_valid = 1'b1; incr_wfid = 6'd7; incr_amount = 4'd3;
        step();
        incr_valid = 1'b0;
        #1;
        checks++; if (rf_writedata !== 11'h001 || rf_writeregsel !== 6'd7) begin errors++; $display("FAIL ovf write got sel=%0d data=%h want 7 001", rf_writeregsel, rf_writedata); end
        checks++; if (upd_valid !== 1'b1 || upd_value !== 11'h7FE || upd_ovf !== 1'b0) begin errors++; $display("FAIL ovf init upd got v=%0b val=%h o=%0b want 1 7fe 0", upd_valid, upd_value, upd_ovf); end
        step();
        checks++; if (upd_valid !== 1'b1 || upd_wfid !== 6'd7 || upd_value !== 11'h001 || upd_ovf !== 1'b1) begin errors++; $display("FAIL ovf upd got v=%0b w=%0d val=%h o=%0b want 1 7 001 1", upd_valid, upd_wfid, upd_value, upd_ovf); end
        step();
        checks++; if (upd_ovf !== 1'b0) begin errors++; $display("FAIL ovf clear got %0b want 0", upd_ovf); end
    endtask

    task automatic test_priority();
        init_valid = 1'b1; init_wfid = 6'd10; init_value = 11'h020;
        incr_valid = 1'b1; incr_wfid = 6'd10; incr_amount = 4'd5;
        #1;
        checks++; if (init_ready !== 1'b1 || incr_ready !== 1'b0) begin errors++; $display("FAIL prio ready got ir=%0b cr=%0b want 1 0", init_ready, incr_ready); end
        step();
        init_valid = 1'b0;
        #1;
        checks++; if (incr_ready !== 1'b1 || rf_writedata !== 11'h020 || rf_writeregsel !== 6'd10) begin errors++; $display("FAIL prio init write got cr=%0b sel=%0d data=%h want 1 10 020", incr_ready, rf_writeregsel, rf_writedata); end
        step();
        incr_valid = 1'b0;
        #1;
        checks++; if (rf_write !== 1'b1 || rf_writedata !== 11'h025) begin errors++; $display("FAIL prio incr write got wr=%0b data=%h want 1 025", rf_write, rf_writedata); end
        step();
        checks++; if (upd_valid !== 1'b1 || upd_value !== 11'h025) begin errors++; $display("FAIL prio upd got v=%0b val=%h want 1 025", upd_valid, upd_value); end
        step();
    endtask

    task automatic test_bad_wfid();
        init_valid = 1'b1; init_wfid = 6'd45; init_value = 11'h003;
        step();
        init_valid = 1'b0;
        #1;
        checks++; if (rf_write !== 1'b0 || err_wfid !== 1'b0) begin errors++; $display("FAIL badw stage got wr=%0b ew=%0b want 0 0", rf_write, err_wfid); end
        step();
        checks++; if (err_wfid !== 1'b1 || upd_valid !== 1'b0) begin errors++; $display("FAIL badw report got ew=%0b uv=%0b want 1 0", err_wfid, upd_valid); end
        step();
        checks++; if (err_wfid !== 1'b0) begin errors++; $display("FAIL badw pulse got %0b want 0", err_wfid); end
    endtask

    task automatic test_flush();
        init_valid = 1'b1; init_wfid = 6'd3; init_value = 11'h033;
        step();
        init_valid = 1'b0;
        step();
        step();
        incr_valid = 1'b1; incr_wfid = 6'd3; incr_amount = 4'd2;
        step();
        incr_wfid = 6'd4; incr_amount = 4'd1; flush_req = 1'b1;
        #1;
        checks++; if (incr_ready !== 1'b0 || init_ready !== 1'b0) begin errors++; $display("FAIL flush ready got ir=%0b cr=%0b want 0 0", init_ready, incr_ready); end
        checks++; if (rf_write !== 1'b1 || rf_writeregsel !== 6'd3 || rf_writedata !== 11'h035) begin errors++; $display("FAIL flush drain got wr=%0b sel=%0d data=%h want 1 3 035", rf_write, rf_writeregsel, rf_writedata); end
        step();
        flush_req = 1'b0; incr_valid = 1'b0;
        #1;
        checks++; if (mem[3] !== 11'h035) begin errors++; $display("FAIL flush slot3 written got %h want 035", mem[3]); end
        checks++; if (upd_valid !== 1'b1 || upd_wfid !== 6'd3 || upd_value !== 11'h035) begin errors++; $display("FAIL flush upd got v=%0b w=%0d val=%h want 1 3 035", upd_valid, upd_wfid, upd_value); end
        checks++; if (rf_write !== 1'b1 || rf_writeregsel !== 6'd0 || rf_writedata !== 11'h000) begin errors++; $display("FAIL flush sweep start got wr=%0b sel=%0d data=%h want 1 0 000", rf_write, rf_writeregsel, rf_writedata); end
        step();
        checks++; if (upd_valid !== 1'b0 || err_wfid !== 1'b0) begin errors++; $display("FAIL flush rejected incr got uv=%0b ew=%0b want 0 0", upd_valid, err_wfid); end
        test_sweep(1, "flush");
        checks++; if (mem[3] !== 11'h000) begin errors++; $display("FAIL flush slot3 cleared got %h want 000", mem[3]); end
    endtask

    task automatic test_reset_mid();
        int n;
        init_valid = 1'b1; init_wfid = 6'd2; init_value = 11'h222;
        step();
        init_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++; if (rf_write !== 1'b1 || rf_writeregsel !== 6'd0 || rf_writedata !== 11'h000) begin errors++; $display("FAIL rmid clear drive got wr=%0b sel=%0d data=%h want 1 0 000", rf_write, rf_writeregsel, rf_writedata); end
        step();
        checks++; if (upd_valid !== 1'b0 || mem[2] !== 11'h000) begin errors++; $display("FAIL rmid discard got uv=%0b slot2=%h want 0 000", upd_valid, mem[2]); end
        rst = 1'b0;
        n = 0;
        while (clear_done !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        checks++; if (n != 40) begin errors++; $display("FAIL rmid sweep length got %0d want 40", n); end
    endtask

    initial begin
        test_reset();
        test_init_incr();
        test_overflow();
        test_priority();
        test_bad_wfid();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
